product_accumulator_4bit: RTL and testbench
===========================================

PRODUCT_ACCUMULATOR_4BIT -- requirements
Module: product_accumulator_4bit

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 16, meaning the number of products summed per frame; the legal range is 1..16.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 SHALL have port a, input, 4 bits: unsigned multiplicand.
REQ-005 SHALL have port b, input, 4 bits: unsigned multiplier.
REQ-006 SHALL have port in_valid, input, 1 bit: a and b are valid this cycle.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts an operand pair this cycle.
REQ-008 SHALL have port out_valid, output, 1 bit: sum holds a completed frame result.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer takes sum this cycle.
REQ-010 SHALL have port sum, output, 12 bits: unsigned frame sum of a*b.
REQ-011 SHALL have port count, output, 5 bits: the number of operand pairs accepted in the current frame.

Function
REQ-012 SHALL accept an operand pair exactly on a rising edge where in_valid=1 and in_ready=1.
REQ-013 SHALL register the 8-bit unsigned product a*b of an accepted pair on the accepting edge (stage 1).
REQ-014 SHALL add the registered product, zero-extended to 12 bits, into a 12-bit accumulator on the following edge (stage 2); no overflow is possible (16*225=3600<4096).
REQ-015 SHALL implement an FSM with states ACCEPT, DRAIN and HOLD.
REQ-016 In ACCEPT, in_ready SHALL be 1; in DRAIN and HOLD, in_ready SHALL be 0.
REQ-017 ACCEPT SHALL go to DRAIN on the edge accepting the FRAME_LEN-th pair; count SHALL then equal FRAME_LEN.
REQ-018 DRAIN SHALL go to HOLD on the next edge, where the final product is accumulated, sum is loaded with the complete total, and out_valid becomes 1.
REQ-019 out_valid SHALL therefore rise exactly one edge after the final accepting edge.
REQ-020 In HOLD, sum and out_valid SHALL remain stable while out_ready=0, and in_valid SHALL be ignored.
REQ-021 On an edge in HOLD with out_ready=1, the block SHALL return to ACCEPT, clear out_valid, the accumulator and count, and leave sum unchanged.
REQ-022 out_ready SHALL be ignored outside HOLD.
REQ-023 Idle cycles (in_valid=0) within a frame SHALL not change the result; only accepted pairs contribute.
REQ-024 With FRAME_LEN=1, each accepted pair SHALL produce a frame: ACCEPT, then DRAIN, then HOLD.
REQ-025 The pipeline SHALL hold no product in stage 1 after leaving DRAIN, so no sample leaks across frames.

Reset
REQ-026 When rst_n=0 on a rising edge, the block SHALL enter ACCEPT and set out_valid=0, sum=0, count=0, accumulator=0 and the stage-1 product-valid flag to 0; in_ready SHALL be 1 after reset.
REQ-027 Reset SHALL take priority over all other inputs, including in the middle of a frame, DRAIN or HOLD; partial sums SHALL be discarded.

Verification
REQ-028 Reset: hold rst_n=0 for 2 edges with in_valid=1 -> out_valid=0, sum=0, count=0, in_ready=1.
REQ-029 Max load: 16 back-to-back pairs with a=15, b=15 and out_ready=1 -> out_valid pulses 1 edge after the 16th accept with sum=3600 (0xE10); no overflow.
REQ-030 Squares: a=b=i for i=0..15 with random in_valid gaps -> sum=1240, independent of the gap pattern.
REQ-031 Backpressure: hold out_ready=0 for 5 cycles in HOLD while driving in_valid=1 -> sum stable, in_ready=0, count=16; raise out_ready -> next frame of 16 pairs with a=1, b=1 yields sum=16.
REQ-032 Mid-frame reset: accept 7 pairs with a=3, b=3, pulse rst_n=0 for 1 edge, then 16 pairs with a=2, b=2 -> sum=64.
REQ-033 FRAME_LEN=1: pairs (5,7) then (15,1) -> two frames with sum=35 and sum=15; in_ready is low for 2 cycles per frame when out_ready=1.

Source files
------------

// File: rtl/product_accumulator_4bit.sv
// Frame multiply-accumulate: sums FRAME_LEN unsigned 4x4 products through a
// two-stage pipeline and presents each frame total with a valid/ready handshake.
module product_accumulator_4bit #(
  parameter int FRAME_LEN = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  a,
  input  logic [3:0]  b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] sum,
  output logic [4:0]  count
);

  localparam logic [1:0] S_ACCEPT = 2'd0;
  localparam logic [1:0] S_DRAIN  = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;
  localparam logic [4:0] LEN      = 5'(FRAME_LEN);

  logic [1:0]  r_state;
  logic [7:0]  r_prod;
  logic        r_prod_vld;
  logic [11:0] r_acc;
  logic [11:0] r_sum;
  logic        r_out_valid;
  logic        r_in_ready;
  logic [4:0]  r_count;

  logic [1:0]  w_state_nxt;
  logic [11:0] w_acc_nxt;
  logic [11:0] w_sum_nxt;
  logic        w_out_valid_nxt;
  logic [4:0]  w_count_nxt;
  logic [7:0]  w_prod;
  logic [11:0] w_acc_add;
  logic        w_accept;

  assign w_prod    = {4'd0, a} * {4'd0, b};
  assign w_acc_add = r_acc + {4'd0, r_prod};
  assign w_accept  = in_valid & r_in_ready;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign count     = r_count;

  // Next-state and datapath update for the ACCEPT/DRAIN/HOLD sequencer
  always_comb begin
    w_state_nxt     = r_state;
    w_count_nxt     = r_count;
    w_sum_nxt       = r_sum;
    w_out_valid_nxt = r_out_valid;
    if (r_prod_vld) begin
      w_acc_nxt = w_acc_add;
    end else begin
      w_acc_nxt = r_acc;
    end

    case (r_state)
      S_ACCEPT: begin
        if (w_accept) begin
          w_count_nxt = r_count + 5'd1;
          if (w_count_nxt == LEN) begin
            w_state_nxt = S_DRAIN;
          end else begin
            w_state_nxt = S_ACCEPT;
          end
        end else begin
          w_count_nxt = r_count;
        end
      end
      // The last product lands in the accumulator on this edge, so the
      // published total is taken from the updated value, not from r_acc.
      S_DRAIN: begin
        w_state_nxt     = S_HOLD;
        w_sum_nxt       = w_acc_nxt;
        w_out_valid_nxt = 1'b1;
      end
      S_HOLD: begin
        if (out_ready) begin
          w_state_nxt     = S_ACCEPT;
          w_out_valid_nxt = 1'b0;
          w_acc_nxt       = 12'd0;
          w_count_nxt     = 5'd0;
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      default: begin
        w_state_nxt     = S_ACCEPT;
        w_out_valid_nxt = 1'b0;
        w_acc_nxt       = 12'd0;
        w_count_nxt     = 5'd0;
      end
    endcase
  end

  // State, pipeline and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_ACCEPT;
      r_prod      <= 8'd0;
      r_prod_vld  <= 1'b0;
      r_acc       <= 12'd0;
      r_sum       <= 12'd0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_count     <= 5'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_prod      <= w_accept ? w_prod : r_prod;
      r_prod_vld  <= w_accept;
      r_acc       <= w_acc_nxt;
      r_sum       <= w_sum_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_in_ready  <= (w_state_nxt == S_ACCEPT);
      r_count     <= w_count_nxt;
    end
  end

endmodule

// File: tb/tb_product_accumulator_4bit.sv
// Scoreboard bench for product_accumulator_4bit with FRAME_LEN=16 and FRAME_LEN=1 instances.
module tb_product_accumulator_4bit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  a0, b0, a1, b1;
  logic        iv0, iv1, or0, or1;
  logic        ir0, ir1, ov0, ov1;
  logic [11:0] s0, s1;
  logic [4:0]  c0, c1;

  product_accumulator_4bit #(.FRAME_LEN(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .a(a0), .b(b0), .in_valid(iv0), .in_ready(ir0),
    .out_valid(ov0), .out_ready(or0), .sum(s0), .count(c0));

  product_accumulator_4bit #(.FRAME_LEN(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(iv1), .in_ready(ir1),
    .out_valid(ov1), .out_ready(or1), .sum(s1), .count(c1));

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int m_sum [2];
  int m_cnt [2];
  int m_last [2];
  int q_sum0 [$];
  int q_cyc0 [$];
  int q_sum1 [$];
  int q_cyc1 [$];
  int es0, ec0, es1, ec1;
  logic pov0 = 1'b0;
  logic pov1 = 1'b0;
  bit rand_or = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every new frame result is popped from the scoreboard and compared
  always @(negedge clk) begin
    if (ov0 && !pov0) begin
      if (q_sum0.size() == 0) chk("unexpected_frame16", 32'd1, 32'd0);
      else begin
        es0 = q_sum0.pop_front();
        ec0 = q_cyc0.pop_front();
        chk("frame16_sum", 32'(s0), 32'(es0));
        chk("frame16_latency", 32'(cyc), 32'(ec0));
      end
    end
    if (ov1 && !pov1) begin
      if (q_sum1.size() == 0) chk("unexpected_frame1", 32'd1, 32'd0);
      else begin
        es1 = q_sum1.pop_front();
        ec1 = q_cyc1.pop_front();
        chk("frame1_sum", 32'(s1), 32'(es1));
        chk("frame1_latency", 32'(cyc), 32'(ec1));
      end
    end
    pov0 <= ov0;
    pov1 <= ov1;
  end

  function automatic int frame_len(input int sel);
    return (sel == 0) ? 16 : 1;
  endfunction

  // Reference model: a frame is simply the sum of the products of accepted pairs
  task automatic model_accept(input int sel, input int p);
    m_sum[sel] += p;
    m_cnt[sel]++;
    if (m_cnt[sel] == frame_len(sel)) begin
      m_last[sel] = m_sum[sel];
      if (sel == 0) begin q_sum0.push_back(m_sum[sel]); q_cyc0.push_back(cyc + 1); end
      else begin q_sum1.push_back(m_sum[sel]); q_cyc1.push_back(cyc + 1); end
      m_sum[sel] = 0;
      m_cnt[sel] = 0;
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic send(input int sel, input logic [3:0] pa, input logic [3:0] pb);
    int n;
    logic rdy;
    n = 0;
    forever begin
      if (rand_or) begin
        if (sel == 0) or0 = 1'($urandom_range(0, 1));
        else or1 = 1'($urandom_range(0, 1));
      end
      if (sel == 0) begin a0 = pa; b0 = pb; iv0 = 1'b1; rdy = ir0; end
      else begin a1 = pa; b1 = pb; iv1 = 1'b1; rdy = ir1; end
      @(negedge clk);
      if (rdy) begin
        model_accept(sel, int'(pa) * int'(pb));
        break;
      end
      n++;
      if (n > 60) begin
        chk("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    iv0 = 1'b0;
    iv1 = 1'b0;
  endtask

  task automatic idle(input int n);
    iv0 = 1'b0;
    iv1 = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 2; i++) begin m_sum[i] = 0; m_cnt[i] = 0; end
  endtask

  initial begin
    rst_n = 1'b0; iv0 = 1'b1; iv1 = 1'b1; or0 = 1'b0; or1 = 1'b0;
    a0 = 4'd15; b0 = 4'd15; a1 = 4'd15; b1 = 4'd15;
    clear_model();
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(ov0), 32'd0);
    chk("rst_sum", 32'(s0), 32'd0);
    chk("rst_count", 32'(c0), 32'd0);
    chk("rst_in_ready", 32'(ir0), 32'd1);
    chk("rst_in_ready_fl1", 32'(ir1), 32'd1);
    rst_n = 1'b1; iv0 = 1'b0; iv1 = 1'b0;
    idle(2);
    chk("idle_count", 32'(c0), 32'd0);

    // Max load: back-to-back 15*15, check the one-cycle result pulse
    or0 = 1'b1;
    for (int i = 0; i < 16; i++) send(0, 4'd15, 4'd15);
    chk("maxload_drain_in_ready", 32'(ir0), 32'd0);
    chk("maxload_drain_count", 32'(c0), 32'd16);
    chk("maxload_drain_out_valid", 32'(ov0), 32'd0);
    @(negedge clk);
    chk("maxload_sum", 32'(s0), 32'd3600);
    chk("maxload_out_valid", 32'(ov0), 32'd1);
    @(negedge clk);
    chk("maxload_pulse_end", 32'(ov0), 32'd0);
    chk("maxload_count_clear", 32'(c0), 32'd0);
    chk("maxload_sum_kept", 32'(s0), 32'd3600);
    chk("maxload_in_ready_back", 32'(ir0), 32'd1);

    // Squares with random gaps, twice with different gap patterns
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 16; i++) begin
        send(0, 4'(i), 4'(i));
        idle($urandom_range(0, 3));
      end
      idle(3);
      chk("squares_sum", 32'(s0), 32'd1240);
    end

    // Backpressure with in_valid held high in HOLD
    or0 = 1'b0;
    for (int i = 0; i < 16; i++) send(0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    @(negedge clk);
    a0 = 4'd9; b0 = 4'd9; iv0 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_sum_stable", 32'(s0), 32'(m_last[0]));
      chk("bp_out_valid", 32'(ov0), 32'd1);
      chk("bp_in_ready", 32'(ir0), 32'd0);
      chk("bp_count", 32'(c0), 32'd16);
      @(negedge clk);
    end
    iv0 = 1'b0; or0 = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 32'(ov0), 32'd0);
    chk("bp_release_count", 32'(c0), 32'd0);
    for (int i = 0; i < 16; i++) send(0, 4'd1, 4'd1);
    idle(2);
    chk("bp_next_sum", 32'(s0), 32'd16);

    // Mid-frame reset discards the partial sum
    for (int i = 0; i < 7; i++) send(0, 4'd3, 4'd3);
    chk("midrst_count_before", 32'(c0), 32'd7);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    chk("midrst_count", 32'(c0), 32'd0);
    chk("midrst_in_ready", 32'(ir0), 32'd1);
    for (int i = 0; i < 16; i++) send(0, 4'd2, 4'd2);
    idle(2);
    chk("midrst_sum", 32'(s0), 32'd64);

    // Random frames with random out_ready backpressure
    rand_or = 1'b1;
    for (int i = 0; i < 48; i++) begin
      send(0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    rand_or = 1'b0;
    or0 = 1'b1;

    // FRAME_LEN=1: each pair is a frame; in_ready low for two cycles
    or1 = 1'b1;
    send(1, 4'd5, 4'd7);
    chk("fl1_drain_in_ready", 32'(ir1), 32'd0);
    chk("fl1_drain_count", 32'(c1), 32'd1);
    @(negedge clk);
    chk("fl1_hold_in_ready", 32'(ir1), 32'd0);
    chk("fl1_sum_a", 32'(s1), 32'd35);
    @(negedge clk);
    chk("fl1_ready_back", 32'(ir1), 32'd1);
    chk("fl1_valid_cleared", 32'(ov1), 32'd0);
    send(1, 4'd15, 4'd1);
    @(negedge clk);
    chk("fl1_sum_b", 32'(s1), 32'd15);
    @(negedge clk);
    rand_or = 1'b1;
    for (int i = 0; i < 12; i++) send(1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    rand_or = 1'b0;
    or1 = 1'b1;

    for (int k = 0; k < 100 && (q_sum0.size() + q_sum1.size()) != 0; k++) @(negedge clk);
    chk("scoreboard_empty", 32'(q_sum0.size() + q_sum1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
